// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480@60 VGA raster timing, VRAM scan-out and vblank reporting
module vga_scanout #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic [11:0] bg_rgb,
  output logic [18:0] vram_addr,
  input  logic [11:0] vram_dout,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vblank,
  output logic        vblank_irq
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACT);
  localparam logic [HW-1:0] H_LAST_PIX = HW'(H_ACT - 1);
  localparam logic [HW-1:0] HS_START   = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END     = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACT);
  localparam logic [VW-1:0] V_LAST_ROW = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VS_START   = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END     = VW'(V_ACT + V_FP + V_SYNC);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [HW-1:0] hcnt_nxt;
  logic [VW-1:0] vcnt_nxt;
  logic          h_wrap;
  logic          v_wrap;
  logic          frame_wrap;
  logic          active;
  logic          hs_raw;
  logic          vs_raw;
  logic          addr_inc;
  logic          disp_en_q;

  // First pipeline stage: counter-domain qualifiers delayed to match VRAM read latency
  logic          active_d;
  logic          hs_d;
  logic          vs_d;

  // Raster position decode and next-state of the counters
  always_comb begin
    h_wrap     = (hcnt == H_MAX);
    v_wrap     = (vcnt == V_MAX);
    frame_wrap = h_wrap && v_wrap;
    hcnt_nxt   = h_wrap ? '0 : hcnt + 1'b1;
    vcnt_nxt   = vcnt;
    if (h_wrap) begin
      vcnt_nxt = v_wrap ? '0 : vcnt + 1'b1;
    end
    active = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
    hs_raw = !((hcnt >= HS_START) && (hcnt < HS_END));
    vs_raw = !((vcnt >= VS_START) && (vcnt < VS_END));
    // Step the address whenever the next position is a visible pixel other than (0,0):
    // along a visible line, and across the line wrap into the next visible row.
    addr_inc = (active && (hcnt != H_LAST_PIX)) ||
               (h_wrap && (vcnt < V_LAST_ROW));
  end

  // Counters, linear VRAM address, frame-latched display enable and vblank status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt       <= '0;
      vcnt       <= '0;
      vram_addr  <= '0;
      disp_en_q  <= 1'b0;
      vblank     <= 1'b0;
      vblank_irq <= 1'b0;
    end else begin
      hcnt <= hcnt_nxt;
      vcnt <= vcnt_nxt;
      if (frame_wrap) begin
        vram_addr <= '0;
      end else if (addr_inc) begin
        vram_addr <= vram_addr + 19'd1;
      end
      if (frame_wrap) begin
        disp_en_q <= disp_en;
      end
      vblank     <= (vcnt_nxt >= V_ACT_C);
      vblank_irq <= h_wrap && (vcnt == V_LAST_ROW);
    end
  end

  // Delay stage 1: qualifiers travel alongside the VRAM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_d <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
    end else begin
      active_d <= active;
      hs_d     <= hs_raw;
      vs_d     <= vs_raw;
    end
  end

  // Delay stage 2: registered pins, colour gated to black outside the active area
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
    end else begin
      vga_hs <= hs_d;
      vga_vs <= vs_d;
      if (!active_d) begin
        {vga_r, vga_g, vga_b} <= 12'h000;
      end else if (disp_en_q) begin
        {vga_r, vga_g, vga_b} <= vram_dout;
      end else begin
        {vga_r, vga_g, vga_b} <= bg_rgb;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed checks of vga_scanout on a reduced raster
module tb_vga_scanout;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int NRUN = 541;
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_en;
  logic [11:0] bg_rgb;
  logic [18:0] vram_addr;
  logic [11:0] vram_dout;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vblank, vblank_irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          n;
    logic [18:0] addr;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        vb;
    logic        irq;
  } vec_t;

  vec_t vt [NV];

  always #20 clk = ~clk;

  vga_scanout #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .bg_rgb(bg_rgb),
    .vram_addr(vram_addr), .vram_dout(vram_dout),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vblank(vblank), .vblank_irq(vblank_irq)
  );

  // VRAM port B model: ram[a] = a[11:0], one-cycle read latency
  always @(posedge clk) vram_dout <= vram_addr[11:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int p);
    int h, v;
    h = p % HT;
    v = p / HT;
    if (v >= VA) return VA * HA - 1;
    if (h >= HA) return v * HA + HA - 1;
    return v * HA + h;
  endfunction

  function automatic logic [11:0] rgb_now();
    return {vga_r, vga_g, vga_b};
  endfunction

  int k, e_hs, e_vs, e_vb, e_irq, q, pq, qh, qv, f, p;
  logic [11:0] e_rgb;
  int err_addr = 0, err_hs = 0, err_vs = 0, err_rgb = 0, err_vb = 0, err_irq = 0;
  int first_fall = -1, last_fall = -1, per_min = 9999, per_max = 0, low_min = 9999, low_max = 0;
  int vs_low0 = 0, vb_high0 = 0, irq0 = 0, irq0_n = -1, irq_all = 0;
  logic prev_hs;

  initial begin
    vt[0]  = '{0,   19'd0,  1, 1, 12'h000, 0, 0};
    vt[1]  = '{2,   19'd2,  1, 1, 12'hF0A, 0, 0};
    vt[2]  = '{7,   19'd7,  1, 1, 12'hF0A, 0, 0};
    vt[3]  = '{9,   19'd7,  1, 1, 12'hF0A, 0, 0};
    vt[4]  = '{10,  19'd7,  1, 1, 12'h000, 0, 0};
    vt[5]  = '{12,  19'd7,  0, 1, 12'h000, 0, 0};
    vt[6]  = '{15,  19'd7,  1, 1, 12'h000, 0, 0};
    vt[7]  = '{16,  19'd8,  1, 1, 12'h000, 0, 0};
    vt[8]  = '{18,  19'd10, 1, 1, 12'hF0A, 0, 0};
    vt[9]  = '{96,  19'd47, 1, 1, 12'h000, 1, 1};
    vt[10] = '{97,  19'd47, 1, 1, 12'h000, 1, 0};
    vt[11] = '{114, 19'd47, 1, 0, 12'h000, 1, 0};
    vt[12] = '{176, 19'd0,  1, 1, 12'h000, 0, 0};
    vt[13] = '{180, 19'd4,  1, 1, 12'h002, 0, 0};
    vt[14] = '{231, 19'd31, 1, 1, 12'h01D, 0, 0};
    vt[15] = '{262, 19'd46, 1, 1, 12'h02C, 0, 0};
    vt[16] = '{357, 19'd5,  1, 1, 12'hF0A, 0, 0};
    vt[17] = '{362, 19'd7,  1, 1, 12'h000, 0, 0};

    rst_n   = 1'b0;
    disp_en = 1'b1;
    bg_rgb  = 12'hF0A;
    repeat (3) @(negedge clk);
    chk("rst_addr", vram_addr, 0);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_rgb", rgb_now(), 0);
    chk("rst_vblank", vblank, 0);
    chk("rst_irq", vblank_irq, 0);

    rst_n = 1'b1;
    prev_hs = 1'b1;
    k = 0;
    for (int n = 0; n < NRUN; n++) begin
      if (n > 0) @(negedge clk);
      // table checkpoints
      if (k < NV && vt[k].n == n) begin
        chk($sformatf("v%0d_addr", n), vram_addr, vt[k].addr);
        chk($sformatf("v%0d_hs", n), vga_hs, vt[k].hs);
        chk($sformatf("v%0d_vs", n), vga_vs, vt[k].vs);
        chk($sformatf("v%0d_rgb", n), rgb_now(), vt[k].rgb);
        chk($sformatf("v%0d_vblank", n), vblank, vt[k].vb);
        chk($sformatf("v%0d_irq", n), vblank_irq, vt[k].irq);
        k++;
      end
      // per-cycle reference from the raster position
      p = n % FR;
      if (n < 2) begin
        e_hs = 1; e_vs = 1; e_rgb = 12'h000;
      end else begin
        q = n - 2;
        pq = q % FR;
        qh = pq % HT;
        qv = pq / HT;
        f = q / FR;
        e_hs = (qh >= HA + HF && qh < HA + HF + HS) ? 0 : 1;
        e_vs = (qv >= VA + VF && qv < VA + VF + VS) ? 0 : 1;
        if (qh < HA && qv < VA) e_rgb = (f == 1) ? 12'(exp_addr(pq)) : 12'hF0A;
        else e_rgb = 12'h000;
      end
      e_vb = (p / HT >= VA) ? 1 : 0;
      e_irq = (p == VA * HT) ? 1 : 0;
      if (vram_addr !== 19'(exp_addr(p))) err_addr++;
      if (vga_hs !== 1'(e_hs)) err_hs++;
      if (vga_vs !== 1'(e_vs)) err_vs++;
      if (rgb_now() !== e_rgb) err_rgb++;
      if (vblank !== 1'(e_vb)) err_vb++;
      if (vblank_irq !== 1'(e_irq)) err_irq++;
      // sync / vblank measurements
      if (prev_hs && !vga_hs) begin
        if (first_fall < 0) first_fall = n;
        else begin
          if (n - last_fall < per_min) per_min = n - last_fall;
          if (n - last_fall > per_max) per_max = n - last_fall;
        end
        last_fall = n;
      end
      if (!prev_hs && vga_hs && last_fall >= 0) begin
        if (n - last_fall < low_min) low_min = n - last_fall;
        if (n - last_fall > low_max) low_max = n - last_fall;
      end
      prev_hs = vga_hs;
      if (n >= 2 && n < FR + 2 && !vga_vs) vs_low0++;
      if (n < FR && vblank) vb_high0++;
      if (n < FR && vblank_irq) begin irq0++; irq0_n = n; end
      if (n < 3 * FR && vblank_irq) irq_all++;
      if (n == 236) disp_en = 1'b0;
    end

    chk("scan_addr", err_addr, 0);
    chk("scan_hs", err_hs, 0);
    chk("scan_vs", err_vs, 0);
    chk("scan_rgb", err_rgb, 0);
    chk("scan_vblank", err_vb, 0);
    chk("scan_irq", err_irq, 0);
    chk("hs_first_fall", first_fall, 12);
    chk("hs_period_min", per_min, HT);
    chk("hs_period_max", per_max, HT);
    chk("hs_low_min", low_min, HS);
    chk("hs_low_max", low_max, HS);
    chk("vs_low_cycles", vs_low0, VS * HT);
    chk("vblank_cycles", vb_high0, (VT - VA) * HT);
    chk("irq_per_frame", irq0, 1);
    chk("irq_cycle", irq0_n, VA * HT);
    chk("irq_three_frames", irq_all, 3);

    // Mid-line asynchronous reset: hs pin low and address nonzero right now
    chk("pre_rst_hs", vga_hs, 0);
    chk("pre_rst_addr", vram_addr, 7);
    #5 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", vram_addr, 0);
    chk("mid_rst_hs", vga_hs, 1);
    chk("mid_rst_vs", vga_vs, 1);
    chk("mid_rst_rgb", rgb_now(), 0);
    chk("mid_rst_vblank", vblank, 0);
    chk("mid_rst_irq", vblank_irq, 0);
    disp_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 0) chk("rel_addr0", vram_addr, 0);
      if (n == 0) chk("rel_hs0", vga_hs, 1);
      if (n == 2) chk("rel_rgb2", rgb_now(), 12'hF0A);
      if (n == 5) chk("rel_addr5", vram_addr, 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display scan-out engine for the VGA peripheral. It generates 640x480@60 Hz raster timing from a single 25 MHz pixel clock and drives the read port (port B) of the dual-port VRAM with a linear pixel address. It turns the 12-bit RGB444 read data into registered, sync-aligned VGA pins, and reports vertical blanking to the CPU side.

## Interface
Parameters:
- H_ACT, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACT, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  pixel clock, 25 MHz; also clocks VRAM port B
- rst_n  in  1  asynchronous, active-low reset
- disp_en  in  1  1 = show VRAM contents, 0 = fill active area with bg_rgb
- bg_rgb  in  12  background colour {R[11:8],G[7:4],B[3:0]}
- vram_addr  out  19  VRAM port B address; web is tied 0 externally
- vram_dout  in  12  VRAM port B read data, valid 1 clk after address
- vga_r / vga_g / vga_b  out  4 each  colour outputs, registered
- vga_hs / vga_vs  out  1 each  syncs, active-low, registered
- vblank  out  1  level, high while the raster line is >= V_ACT
- vblank_irq  out  1  1-clk pulse at the start of vertical blanking

## Operation
- Counters: hcnt 0..H_TOTAL-1 (800) and vcnt 0..V_TOTAL-1 (525).
  - hcnt wraps to 0 after 799.
  - vcnt increments when hcnt wraps, and wraps to 0 after 524.
- active = (hcnt < H_ACT) && (vcnt < V_ACT).
- Sync windows, evaluated on the counters:
  - hs_raw low for H_ACT+H_FP <= hcnt < H_ACT+H_FP+H_SYNC (656..751).
  - vs_raw low for V_ACT+V_FP <= vcnt < V_ACT+V_FP+V_SYNC (490..491).
- Address counter: vram_addr is a register equal to vcnt*H_ACT+hcnt whenever active. It is built incrementally; no multiplier.
  - It increments when active and not at the last visible pixel (639,479).
  - It holds during horizontal and vertical blanking, so it stays at 307199 through vblank.
  - It clears to 0 on the (799,524) -> (0,0) wrap.
  - It never exceeds 307199.
- disp_en is sampled into disp_en_q only on the frame wrap, so a change never tears a frame. disp_en_q resets to 0.
- Colour select at output stage: not active_d -> 0x000; active_d && disp_en_q -> vram_dout; active_d && !disp_en_q -> bg_rgb.
- vblank is a registered copy of (vcnt >= V_ACT).
- vblank_irq is high for exactly the cycle vblank rises, i.e. vcnt 479 -> 480 at hcnt wrap.

## Timing
- Pipeline, with counters at (h,v) in cycle t:
  - Cycle t: vram_addr for (h,v) is presented.
  - Cycle t+1: vram_dout is valid.
  - Cycle t+2: vga_r/g/b registered out.
- active, hs_raw and vs_raw are delayed by 2 registers so the syncs and the blank gate align with the colour. Pixel-to-pin latency is therefore 2 clk.
- vblank and vblank_irq are not delayed; they are counter-domain, for the CPU only.
- Reset (async, immediate on rst_n low) applies these values:
  - hcnt = vcnt = 0, vram_addr = 0.
  - Colour outputs 0.
  - vga_hs = vga_vs = 1, including the delay stages.
  - vblank = 0, vblank_irq = 0, disp_en_q = 0.
- Reset mid-frame restarts the raster at (0,0) with addr 0. The first frame after reset shows bg_rgb in the active area because disp_en_q = 0.
- First colour-bearing output after rst_n release: cycle 2, pixel (0,0).

## Test plan
- Reset: assert rst_n=0 mid-line -> all outputs take reset values immediately, with vga_hs=vga_vs=1 and colour 0. Release -> hcnt restarts at 0.
- hsync timing: count clk between vga_hs falling edges -> 800. Low width -> 96. Falling edge 658 clk after the pixel-0 counter cycle (656+2).
- vsync and vblank: vga_vs low for 2x800 = 1600 clk per 525-line frame. vblank high for 45 lines. vblank_irq one pulse per frame, 480x800 clk after frame start.
- Address sequence: vram_addr = 0 at (0,0) and 639 at (639,0). Holds 639 through hblank. 640 at (0,1). Holds 307199 in vblank. 0 after the wrap.
- Data path: VRAM model with ram[a] = a[11:0], disp_en=1 from before frame 2 -> in frame 2, the pin value 2 clk after the address is presented equals that address[11:0]. Output is 0x000 in all blanking cycles.
- disp_en and bg_rgb: bg_rgb=0xF0A, toggle disp_en 1 -> 0 mid-frame -> the current frame still shows VRAM data. The next frame shows 0xF0A in the active area and 0x000 in blanking.
